// File: rtl/button_event_scheduler.sv
// Per-channel press / long-press detection feeding a round-robin event queue
// with one pending slot per (channel, event type) and a valid/ready output.
//
// state | meaning
// IDLE  | channel released, waiting for a press
// HELD  | press reported, counting sample ticks toward a long press
// LONG  | long press reported, silent until release
module button_event_scheduler #(
   parameter int width              = 4,
   parameter int sample_count_max   = 25000,
   parameter int long_press_samples = 150,
   localparam int IW = (width > 1) ? $clog2(width) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [width-1:0] debounced_signal,
   output logic             sample_now,
   output logic             event_valid,
   input  logic             event_ready,
   output logic [IW-1:0]    event_idx,
   output logic             event_long,
   output logic             overflow
);

   localparam int N  = 2 * width;
   localparam int PW = $clog2(N);
   localparam int SW = $clog2(sample_count_max);
   localparam int HW = $clog2(long_press_samples + 1);
   localparam logic [SW-1:0] SAMPLE_LAST = SW'(sample_count_max - 1);
   localparam logic [HW-1:0] HOLD_LAST   = HW'(long_press_samples - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HELD = 2'd1,
      LONG = 2'd2
   } ch_state_t;

   logic [SW-1:0] sample_cnt;
   ch_state_t     state    [width];
   logic [HW-1:0] hold_cnt [width];
   logic [N-1:0]  req;
   logic [N-1:0]  pending;
   logic [N-1:0]  clr;
   logic [PW-1:0] ptr;
   logic [PW-1:0] pick;
   logic          found;
   logic          load;
   logic          drop;
   int            j;

   assign sample_now = (sample_cnt == SAMPLE_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_cnt <= '0;
      end else if (sample_now) begin
         sample_cnt <= '0;
      end else begin
         sample_cnt <= sample_cnt + 1'b1;
      end
   end

   // Requests are decoded from the transition itself so a press reaches the
   // pending bits on the same edge the FSM leaves IDLE.
   always_comb begin
      req = '0;
      for (int i = 0; i < width; i++) begin
         req[2*i]   = (state[i] == IDLE) && debounced_signal[i];
         req[2*i+1] = (state[i] == HELD) && debounced_signal[i] && sample_now
                      && (hold_cnt[i] == HOLD_LAST);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < width; i++) begin
            state[i]    <= IDLE;
            hold_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < width; i++) begin
            if (!debounced_signal[i]) begin
               state[i]    <= IDLE;
               hold_cnt[i] <= '0;
            end else begin
               case (state[i])
                  IDLE: begin
                     state[i]    <= HELD;
                     hold_cnt[i] <= '0;
                  end
                  HELD: begin
                     if (sample_now) begin
                        if (hold_cnt[i] == HOLD_LAST) state[i] <= LONG;
                        else hold_cnt[i] <= hold_cnt[i] + 1'b1;
                     end
                  end
                  LONG: ;
                  default: begin
                     state[i]    <= IDLE;
                     hold_cnt[i] <= '0;
                  end
               endcase
            end
         end
      end
   end

   // First pending bit at or after the pointer, wrapping modulo N.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!found && pending[PW'(j)]) begin
            found = 1'b1;
            pick  = PW'(j);
         end
      end
   end

   assign load = !event_valid || event_ready;

   always_comb begin
      clr = '0;
      if (load && found) clr[pick] = 1'b1;
   end

   // A set landing on a bit that is being granted this cycle is kept, not dropped.
   assign drop = |(req & pending & ~clr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending     <= '0;
         ptr         <= '0;
         event_valid <= 1'b0;
         event_idx   <= '0;
         event_long  <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         pending  <= (pending & ~clr) | req;
         overflow <= drop;
         if (load) begin
            event_valid <= found;
            if (found) begin
               event_idx  <= IW'(pick >> 1);
               event_long <= pick[0];
               ptr        <= (pick == PW'(N - 1)) ? '0 : pick + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_button_event_scheduler.sv
// Bench for button_event_scheduler: directed scenarios plus a randomized run
// against a behavioural model of press tracking, pending slots and round-robin grant.
module tb_button_event_scheduler;

   localparam int W   = 4;
   localparam int SCM = 4;
   localparam int L   = 3;
   localparam int N   = 2 * W;
   localparam int IW  = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          event_ready = 1'b0;
   logic [W-1:0]  sig = '0;
   logic          sample_now;
   logic          event_valid;
   logic          event_long;
   logic          overflow;
   logic [IW-1:0] event_idx;

   int checks = 0;
   int errors = 0;

   // behavioural model state
   int         m_cnt;
   int         m_ptr;
   int         m_idx;
   bit         m_valid;
   bit         m_lg;
   bit         m_ovf;
   bit         m_down  [W];
   int         m_ticks [W];
   bit [N-1:0] m_pend;

   button_event_scheduler #(
      .width(W),
      .sample_count_max(SCM),
      .long_press_samples(L)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .debounced_signal(sig),
      .sample_now(sample_now),
      .event_valid(event_valid),
      .event_ready(event_ready),
      .event_idx(event_idx),
      .event_long(event_long),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_cnt = 0; m_ptr = 0; m_idx = 0;
      m_valid = 0; m_lg = 0; m_ovf = 0; m_pend = '0;
      for (int i = 0; i < W; i++) begin
         m_down[i] = 0;
         m_ticks[i] = 0;
      end
   endtask

   // One clock of the model, using the inputs that were present before the edge.
   task automatic model_step();
      bit         tk;
      bit [N-1:0] req;
      bit [N-1:0] old;
      int         pick;
      if (!rst_n) begin
         model_reset();
         return;
      end
      tk  = (m_cnt == SCM - 1);
      req = '0;
      for (int i = 0; i < W; i++) begin
         if (!sig[i]) begin
            m_down[i] = 0;
            m_ticks[i] = 0;
         end else if (!m_down[i]) begin
            m_down[i] = 1;
            m_ticks[i] = 0;
            req[2*i] = 1;
         end else if (tk && m_ticks[i] < L) begin
            m_ticks[i]++;
            if (m_ticks[i] == L) req[2*i+1] = 1;
         end
      end
      old  = m_pend;
      pick = -1;
      if (!m_valid || event_ready) begin
         for (int k = 0; k < N; k++)
            if (pick < 0 && old[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
         m_valid = (pick >= 0);
         if (pick >= 0) begin
            m_idx = pick / 2;
            m_lg  = bit'(pick % 2);
            m_ptr = (pick + 1) % N;
         end
      end
      m_ovf = 0;
      for (int r = 0; r < N; r++)
         if (req[r] && old[r] && r != pick) m_ovf = 1;
      m_pend = old;
      if (pick >= 0) m_pend[pick] = 0;
      m_pend = m_pend | req;
      m_cnt = (m_cnt + 1) % SCM;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      tick();
      tick();
      checks++;
      if ({sample_now, event_valid, event_idx, event_long, overflow} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got=%b want=0",
                  {sample_now, event_valid, event_idx, event_long, overflow});
      end
   endtask

   task automatic test_sample_tick();
      sig = '0;
      event_ready = 1'b0;
      rst_n = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         checks++;
         if (sample_now !== ((e % 4) == 0)) begin
            errors++;
            $display("FAIL sample_now edge=%0d got=%b want=%b", e, sample_now, (e % 4) == 0);
         end
         checks++;
         if (event_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_valid edge=%0d got=%b want=0", e, event_valid);
         end
         tick();
      end
   endtask

   task automatic test_press_long();
      int log_q[$];
      int first_v;
      int late;
      first_v = -1;
      late = 0;
      event_ready = 1'b1;
      sig = 4'b0100;
      for (int c = 0; c < 40; c++) begin
         if (event_valid && first_v < 0) first_v = c;
         if (event_valid && event_ready) log_q.push_back(int'(event_idx) * 2 + int'(event_long));
         tick();
      end
      checks++;
      if (first_v !== 2) begin
         errors++;
         $display("FAIL press_latency got=%0d want=2", first_v);
      end
      sig = '0;
      for (int c = 0; c < 20; c++) begin
         if (event_valid) late++;
         tick();
      end
      checks++;
      if (late !== 0) begin
         errors++;
         $display("FAIL release_no_event got=%0d want=0", late);
      end
      checks++;
      if (log_q.size() !== 2) begin
         errors++;
         $display("FAIL press_long_count got=%0d want=2", log_q.size());
      end else begin
         checks++;
         if (log_q[0] !== 4 || log_q[1] !== 5) begin
            errors++;
            $display("FAIL press_long_events got=%0d,%0d want=4,5", log_q[0], log_q[1]);
         end
      end
   endtask

   task automatic test_simultaneous();
      bit ev [5] = '{0, 1, 1, 1, 0};
      int ei [5] = '{0, 0, 1, 3, 0};
      do_reset();
      event_ready = 1'b1;
      sig = 4'b1011;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if (event_valid !== ev[k] || (ev[k] && (event_idx !== IW'(ei[k]) || event_long !== 1'b0))) begin
            errors++;
            $display("FAIL simultaneous k=%0d got v=%b i=%0d l=%b want v=%b i=%0d l=0",
                     k, event_valid, event_idx, event_long, ev[k], ei[k]);
         end
      end
      sig = '0;
      tick();
   endtask

   task automatic test_overflow();
      bit seq  [6] = '{1, 0, 1, 0, 1, 0};
      bit eovf [6] = '{0, 0, 0, 0, 1, 0};
      bit ev   [6] = '{0, 1, 1, 1, 1, 1};
      int acc;
      int bad;
      acc = 0;
      bad = 0;
      do_reset();
      event_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         sig = {2'b00, seq[k], 1'b0};
         tick();
         checks++;
         if (overflow !== eovf[k]) begin
            errors++;
            $display("FAIL overflow k=%0d got=%b want=%b", k, overflow, eovf[k]);
         end
         checks++;
         if (event_valid !== ev[k] || (ev[k] && (event_idx !== 2'd1 || event_long !== 1'b0))) begin
            errors++;
            $display("FAIL held_event k=%0d got v=%b i=%0d l=%b want v=%b i=1 l=0",
                     k, event_valid, event_idx, event_long, ev[k]);
         end
      end
      event_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (event_valid) begin
            acc++;
            if (event_idx !== 2'd1 || event_long !== 1'b0) bad++;
         end
         tick();
      end
      checks++;
      if (acc !== 2 || bad !== 0) begin
         errors++;
         $display("FAIL drain_after_overflow got=%0d(bad %0d) want=2(bad 0)", acc, bad);
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      int first;
      do_reset();
      event_ready = 1'b0;
      sig = 4'b1110;
      tick();
      sig = '0;
      tick();
      tick();
      checks++;
      if (event_valid !== 1'b1 || event_idx !== 2'd1) begin
         errors++;
         $display("FAIL pre_reset_event got v=%b i=%0d want v=1 i=1", event_valid, event_idx);
      end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({sample_now, event_valid, event_idx, event_long, overflow} !== '0) begin
         errors++;
         $display("FAIL async_reset got=%b want=0",
                  {sample_now, event_valid, event_idx, event_long, overflow});
      end
      @(negedge clk);
      tick();
      rst_n = 1'b1;
      event_ready = 1'b1;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         if (event_valid) seen++;
         tick();
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL post_reset_quiet got=%0d want=0", seen);
      end
      rst_n = 1'b0;
      model_reset();
      sig = 4'b0001;
      tick();
      rst_n = 1'b1;
      first = -1;
      for (int c = 0; c < 6; c++) begin
         if (event_valid && first < 0 && event_idx == 2'd0 && !event_long) first = c;
         tick();
      end
      checks++;
      if (first !== 2) begin
         errors++;
         $display("FAIL held_through_reset got=%0d want=2", first);
      end
      sig = '0;
      tick();
   endtask

   task automatic test_fairness();
      int log_q[$];
      int n0;
      int rep;
      n0 = 0;
      rep = 0;
      do_reset();
      event_ready = 1'b1;
      for (int c = 0; c < 24; c++) begin
         sig = ((c % 2) == 0 && c < 12) ? 4'b1001 : 4'b0000;
         if (event_valid && event_ready) log_q.push_back(int'(event_idx));
         tick();
      end
      foreach (log_q[k]) begin
         if (log_q[k] == 0) n0++;
         if (k > 0 && log_q[k] == log_q[k-1]) rep++;
      end
      checks++;
      if (log_q.size() !== 12 || n0 !== 6 || rep !== 0) begin
         errors++;
         $display("FAIL fairness got n=%0d ch0=%0d repeats=%0d want n=12 ch0=6 repeats=0",
                  log_q.size(), n0, rep);
      end
   endtask

   task automatic test_random();
      int nev;
      nev = 0;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < W; i++)
            if ($urandom_range(0, 15) == 0) sig[i] = ~sig[i];
         event_ready = ($urandom_range(0, 3) != 0);
         tick();
         checks++;
         if ({sample_now, event_valid, overflow} !== {m_cnt == SCM - 1, m_valid, m_ovf}) begin
            errors++;
            $display("FAIL random_ctrl c=%0d got s/v/o=%b want=%b", c,
                     {sample_now, event_valid, overflow}, {m_cnt == SCM - 1, m_valid, m_ovf});
         end
         if (m_valid) begin
            nev++;
            checks++;
            if (event_idx !== IW'(m_idx) || event_long !== m_lg) begin
               errors++;
               $display("FAIL random_event c=%0d got i=%0d l=%b want i=%0d l=%b",
                        c, event_idx, event_long, m_idx, m_lg);
            end
         end
      end
      checks++;
      if (nev == 0) begin
         errors++;
         $display("FAIL random_activity got=0 events want>0");
      end
      sig = '0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_sample_tick();
      test_press_long();
      test_simultaneous();
      test_overflow();
      test_reset_mid();
      test_fairness();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
